// File: rtl/seq_mult_iter_pkg.sv
// mult_pkg: shared FSM state type and operand extension helper for arithmetic blocks
package mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} mult_state_t;
  localparam int MAX_W = 64;
  // widen the low w bits of v to 2*MAX_W, replicating bit w-1 when sgn is set
  function automatic logic [2*MAX_W-1:0] extend(input logic [MAX_W-1:0] v, input int unsigned w, input logic sgn);
    logic [2*MAX_W-1:0] lo;
    lo = ((2*MAX_W)'(1) << w) - (2*MAX_W)'(1);
    return (sgn && v[6'(w - 1)]) ? ({{MAX_W{1'b0}}, v} | ~lo) : ({{MAX_W{1'b0}}, v} & lo);
  endfunction
endpackage

// File: rtl/seq_mult_iter_if.sv
// seq_mult_iter_if: start/done request bus between a master and the iterative multiplier
interface seq_mult_iter_if #(parameter int WIDTH = 32);
  logic start, is_signed, busy, done;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] product;
  modport master (output start, is_signed, a, b, input busy, done, product);
  modport slave (input start, is_signed, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_iter_step.sv
// seq_mult_step: one shift-add iteration, adds or subtracts b_ext<<cnt when the multiplier bit is set
module seq_mult_step #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_b_ext,
  input  logic [CNT_W-1:0]   i_cnt,
  input  logic               i_bit,
  input  logic               i_sub,
  output logic [2*WIDTH-1:0] o_acc
);
  logic [2*WIDTH-1:0] w_pp;
  assign w_pp = i_b_ext << i_cnt;
  assign o_acc = !i_bit ? i_acc : i_sub ? i_acc - w_pp : i_acc + w_pp;
endmodule

// File: rtl/seq_mult_iter.sv
// seq_mult_iter: iterative radix-2 shift-add multiplier, signed or unsigned per operation
module seq_mult_iter import mult_pkg::*; #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            rst_n,
  seq_mult_iter_if.slave s
);
  mult_state_t r_state, w_next;
  logic [WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_b_ext, r_acc, r_prod, w_acc_nxt, w_b_ext;
  logic [CNT_W-1:0] r_cnt;
  logic r_sgn, w_accept, w_last;
  assign w_accept = s.start && r_state != RUN;
  assign w_last = r_cnt == CNT_W'(WIDTH - 1);
  assign w_b_ext = (2*WIDTH)'(extend(MAX_W'(s.b), WIDTH, s.is_signed));
  assign s.busy = r_state == RUN;
  assign s.done = r_state == FINISH;
  assign s.product = r_prod;
  always_comb begin
    w_next = w_accept ? RUN : r_state == RUN ? (w_last ? FINISH : RUN) : IDLE;
  end
  // the top partial product of a signed multiplier carries negative weight
  seq_mult_step #(.WIDTH(WIDTH)) u_step (
    .i_acc(r_acc), .i_b_ext(r_b_ext), .i_cnt(r_cnt), .i_bit(r_a[r_cnt]),
    .i_sub(r_sgn && w_last), .o_acc(w_acc_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b_ext <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_sgn <= 1'b0;
      r_prod <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a <= s.a;
        r_b_ext <= w_b_ext;
        r_acc <= '0;
        r_cnt <= '0;
        r_sgn <= s.is_signed;
      end else if (r_state == RUN) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == RUN && w_last) r_prod <= w_acc_nxt;
    end
  end
endmodule

// File: tb/tb_seq_mult_iter.sv
// tb_seq_mult_iter: scoreboard bench for 8- and 32-bit instances against a 64-bit multiply model
module tb_seq_mult_iter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  seq_mult_iter_if #(.WIDTH(8)) m8();
  seq_mult_iter_if #(.WIDTH(32)) m32();
  seq_mult_iter #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .s(m8.slave));
  seq_mult_iter #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .s(m32.slave));
  int n_run = 0, n_fail = 0, n_done8 = 0;
  logic [63:0] q8[$], q32[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int w);
    logic signed [63:0] sa, sb;
    logic [63:0] m;
    m = (64'd1 << (2*w)) - 64'd1;
    sa = sgn ? $signed({a, 32'd0} << (32 - w)) >>> (64 - w) : $signed(64'(a) & ((64'd1 << w) - 64'd1));
    sb = sgn ? $signed({b, 32'd0} << (32 - w)) >>> (64 - w) : $signed(64'(b) & ((64'd1 << w) - 64'd1));
    return 64'(sa * sb) & m;
  endfunction
  always @(negedge clk) begin
    if (m8.done) begin
      n_done8++;
      chk("sb8_pending", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) chk("prod8", 64'(m8.product), q8.pop_front());
    end
    if (m32.done) begin
      chk("sb32_pending", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) chk("prod32", m32.product, q32.pop_front());
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input bit w, input logic [31:0] a, input logic [31:0] b, input logic sgn);
    if (w) begin
      m32.a = a; m32.b = b; m32.is_signed = sgn; m32.start = 1'b1;
      q32.push_back(model(a, b, sgn, 32));
    end else begin
      m8.a = a[7:0]; m8.b = b[7:0]; m8.is_signed = sgn; m8.start = 1'b1;
      q8.push_back(model(a, b, sgn, 8));
    end
    step();
    m8.start = 1'b0; m32.start = 1'b0;
    m8.a = 8'($urandom); m8.b = 8'($urandom); m8.is_signed = 1'($urandom);
    m32.a = $urandom; m32.b = $urandom; m32.is_signed = 1'($urandom);
  endtask
  task automatic wt(input bit w, output int lat, output int bc);
    lat = 1;
    bc = 0;
    while (!(w ? m32.done : m8.done) && lat < 80) begin
      bc += int'(w ? m32.busy : m8.busy);
      step();
      lat++;
    end
    chk("done_seen", 64'(w ? m32.done : m8.done), 64'd1);
  endtask
  task automatic run(input bit w, input logic [31:0] a, input logic [31:0] b, input logic sgn);
    int lat, bc;
    op(w, a, b, sgn);
    wt(w, lat, bc);
    step();
  endtask
  initial begin
    int lat, bc, d0;
    m8.start = 1'b0; m8.a = '0; m8.b = '0; m8.is_signed = 1'b0;
    m32.start = 1'b0; m32.a = '0; m32.b = '0; m32.is_signed = 1'b0;
    repeat (2) step();
    chk("rst_busy", 64'(m8.busy), 64'd0);
    chk("rst_done", 64'(m8.done), 64'd0);
    chk("rst_prod", 64'(m8.product), 64'd0);
    chk("rst_prod32", m32.product, 64'd0);
    rst_n = 1'b1;
    step();
    op(0, 32'hFF, 32'hFF, 1'b0);
    wt(0, lat, bc);
    chk("lat_ff", 64'(lat), 64'd9);
    chk("busy_cycles_ff", 64'(bc), 64'd8);
    chk("busy_in_done", 64'(m8.busy), 64'd0);
    chk("prod_ff_const", 64'(m8.product), 64'hFE01);
    step();
    run(0, 32'h80, 32'h80, 1'b1);
    chk("corner8_const", 64'(m8.product), 64'h4000);
    run(0, 32'hFF, 32'h01, 1'b1);
    chk("neg1_const", 64'(m8.product), 64'hFFFF);
    run(0, 32'h00, 32'h5A, 1'b1);
    run(0, 32'hC3, 32'h00, 1'b0);
    op(0, 32'h05, 32'hFD, 1'b1);
    wt(0, lat, bc);
    op(0, 32'h02, 32'h07, 1'b0);
    chk("b2b_hold", 64'(m8.product), 64'hFFF1);
    chk("b2b_busy", 64'(m8.busy), 64'd1);
    wt(0, lat, bc);
    chk("b2b_lat", 64'(lat), 64'd9);
    chk("b2b_const", 64'(m8.product), 64'h000E);
    step();
    d0 = n_done8;
    op(0, 32'h03, 32'h04, 1'b0);
    repeat (2) step();
    m8.a = 8'h09; m8.b = 8'h09; m8.start = 1'b1;
    step();
    m8.start = 1'b0;
    wt(0, lat, bc);
    repeat (12) step();
    chk("ign_done_count", 64'(n_done8 - d0), 64'd1);
    chk("ign_const", 64'(m8.product), 64'h000C);
    op(0, 32'h03, 32'h05, 1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(m8.busy), 64'd0);
    chk("midrst_done", 64'(m8.done), 64'd0);
    chk("midrst_prod", 64'(m8.product), 64'd0);
    q8.delete();
    step();
    rst_n = 1'b1;
    step();
    run(0, 32'h7B, 32'hC5, 1'b1);
    repeat (40) run(0, $urandom, $urandom, 1'($urandom));
    op(1, 32'h80000000, 32'h80000000, 1'b1);
    wt(1, lat, bc);
    chk("lat32", 64'(lat), 64'd33);
    chk("busy_cycles32", 64'(bc), 64'd32);
    chk("corner32_const", m32.product, 64'h4000000000000000);
    step();
    run(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (1500) run(1, $urandom, $urandom, 1'($urandom));
    repeat (4) step();
    chk("sb8_empty", 64'(q8.size()), 64'd0);
    chk("sb32_empty", 64'(q32.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
